// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline hazard inputs, MDU handshake, register strobes and counters.
// The pipeline side connects as master; the hazard controller connects as slave.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       dec_rs1;
  logic [4:0]       dec_rs2;
  logic             dec_rs1_ren;
  logic             dec_rs2_ren;
  logic             exe_is_load;
  logic [4:0]       exe_rd;
  logic             exe_redirect;
  logic             exe_mdu_op;
  logic             mdu_done;
  logic             mem_req;
  logic             mem_ready;
  logic             imem_valid;
  logic             trap_flush;

  logic             regF_stall;
  logic             regD_stall;
  logic             regD_bubble;
  logic             regE_stall;
  logic             regE_bubble;
  logic             regM_stall;
  logic             regM_bubble;
  logic             regW_bubble;
  logic             mdu_start;
  logic             mdu_kill;
  logic             mdu_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output dec_rs1, dec_rs2, dec_rs1_ren, dec_rs2_ren,
           exe_is_load, exe_rd, exe_redirect, exe_mdu_op,
           mdu_done, mem_req, mem_ready, imem_valid, trap_flush,
    input  regF_stall, regD_stall, regD_bubble, regE_stall, regE_bubble,
           regM_stall, regM_bubble, regW_bubble,
           mdu_start, mdu_kill, mdu_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  dec_rs1, dec_rs2, dec_rs1_ren, dec_rs2_ren,
           exe_is_load, exe_rd, exe_redirect, exe_mdu_op,
           mdu_done, mem_req, mem_ready, imem_valid, trap_flush,
    output regF_stall, regD_stall, regD_bubble, regE_stall, regE_bubble,
           regM_stall, regM_bubble, regW_bubble,
           mdu_start, mdu_kill, mdu_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/bubble generator for the 5-stage pipeline, MUL/DIV sequencer in EX,
// and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int                WAIT_W    = $clog2(MDU_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MDU_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MDU_TIMEOUT - 1);

  typedef enum logic {
    RUN,
    MDU_WAIT
  } state_t;

  // Which rule governs the current cycle; strobes and state updates both key off it.
  typedef enum logic [3:0] {
    C_RESET,
    C_TRAP,
    C_MEM_WAIT,
    C_MDU_BUSY,
    C_MDU_DONE,
    C_MDU_START,
    C_REDIRECT,
    C_LOAD_USE,
    C_FETCH,
    C_NONE
  } cause_t;

  typedef struct packed {
    logic f_stall;
    logic d_stall;
    logic d_bubble;
    logic e_stall;
    logic e_bubble;
    logic m_stall;
    logic m_bubble;
    logic w_bubble;
  } strobe_t;

  state_t            state;
  cause_t            cause;
  strobe_t           strobe;
  logic              load_use;
  logic              stall_any;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mdu_start_q;
  logic              mdu_kill_q;
  logic              mdu_timeout_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  assign load_use = hz.exe_is_load && (hz.exe_rd != 5'd0) &&
                    ((hz.dec_rs1_ren && (hz.dec_rs1 == hz.exe_rd)) ||
                     (hz.dec_rs2_ren && (hz.dec_rs2 == hz.exe_rd)));

  // Priority decode: the first matching rule wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cause = C_NONE;
    if (rst)                                   cause = C_RESET;
    else if (hz.trap_flush)                    cause = C_TRAP;
    else if (hz.mem_req && !hz.mem_ready)      cause = C_MEM_WAIT;
    else if (state == MDU_WAIT && !hz.mdu_done) cause = C_MDU_BUSY;
    else if (state == MDU_WAIT)                cause = C_MDU_DONE;
    else if (hz.exe_mdu_op)                    cause = C_MDU_START;
    else if (hz.exe_redirect)                  cause = C_REDIRECT;
    else if (load_use)                         cause = C_LOAD_USE;
    else if (!hz.imem_valid)                   cause = C_FETCH;
  end

  always_comb begin
    strobe = '0;
    case (cause)
      C_RESET: begin
        strobe.d_bubble = 1'b1;
        strobe.e_bubble = 1'b1;
        strobe.m_bubble = 1'b1;
        strobe.w_bubble = 1'b1;
      end
      C_TRAP: begin
        strobe.d_bubble = 1'b1;
        strobe.e_bubble = 1'b1;
        strobe.m_bubble = 1'b1;
      end
      C_MEM_WAIT: begin
        strobe.f_stall  = 1'b1;
        strobe.d_stall  = 1'b1;
        strobe.e_stall  = 1'b1;
        strobe.m_stall  = 1'b1;
        strobe.w_bubble = 1'b1;
      end
      C_MDU_BUSY, C_MDU_START: begin
        strobe.f_stall  = 1'b1;
        strobe.d_stall  = 1'b1;
        strobe.e_stall  = 1'b1;
        strobe.m_bubble = 1'b1;
      end
      C_REDIRECT: begin
        strobe.d_bubble = 1'b1;
        strobe.e_bubble = 1'b1;
      end
      C_LOAD_USE: begin
        strobe.f_stall  = 1'b1;
        strobe.d_stall  = 1'b1;
        strobe.e_bubble = 1'b1;
      end
      C_FETCH: begin
        strobe.f_stall  = 1'b1;
        strobe.d_bubble = 1'b1;
      end
      default: strobe = '0;
    endcase
  end

  assign stall_any = strobe.f_stall | strobe.d_stall | strobe.e_stall | strobe.m_stall;

  // Sequencer: MDU handshake pulses, wait counter and sticky timeout.
  // A memory wait matches none of the arms, so state and wait counter hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      wait_cnt      <= '0;
      mdu_start_q   <= 1'b0;
      mdu_kill_q    <= 1'b0;
      mdu_timeout_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      mdu_start_q <= 1'b0;
      mdu_kill_q  <= 1'b0;
      case (cause)
        C_TRAP: begin
          if (state == MDU_WAIT) begin
            mdu_kill_q <= 1'b1;
            state      <= RUN;
            wait_cnt   <= '0;
          end
        end
        C_MDU_BUSY: begin
          if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
          if (wait_cnt >= WAIT_LAST) mdu_timeout_q <= 1'b1;
        end
        C_MDU_DONE: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
        C_MDU_START: begin
          mdu_start_q <= 1'b1;
          state       <= MDU_WAIT;
          wait_cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

  // Performance counters saturate at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_any && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if ((cause == C_TRAP || cause == C_REDIRECT) && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hz.regF_stall  = strobe.f_stall;
  assign hz.regD_stall  = strobe.d_stall;
  assign hz.regD_bubble = strobe.d_bubble;
  assign hz.regE_stall  = strobe.e_stall;
  assign hz.regE_bubble = strobe.e_bubble;
  assign hz.regM_stall  = strobe.m_stall;
  assign hz.regM_bubble = strobe.m_bubble;
  assign hz.regW_bubble = strobe.w_bubble;
  assign hz.mdu_start   = mdu_start_q;
  assign hz.mdu_kill    = mdu_kill_q;
  assign hz.mdu_timeout = mdu_timeout_q;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default instance plus a small one
// (CNT_W=4, MDU_TIMEOUT=4) driven by identical stimulus for saturation and timeout.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst;

  pipe_hazard_ctrl_if #(.CNT_W(32)) bus0 ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  bus1 ();

  pipe_hazard_ctrl #(.CNT_W(32), .MDU_TIMEOUT(64)) dut0 (.clk(clk), .rst(rst), .hz(bus0));
  pipe_hazard_ctrl #(.CNT_W(4),  .MDU_TIMEOUT(4))  dut1 (.clk(clk), .rst(rst), .hz(bus1));

  assign bus1.dec_rs1      = bus0.dec_rs1;
  assign bus1.dec_rs2      = bus0.dec_rs2;
  assign bus1.dec_rs1_ren  = bus0.dec_rs1_ren;
  assign bus1.dec_rs2_ren  = bus0.dec_rs2_ren;
  assign bus1.exe_is_load  = bus0.exe_is_load;
  assign bus1.exe_rd       = bus0.exe_rd;
  assign bus1.exe_redirect = bus0.exe_redirect;
  assign bus1.exe_mdu_op   = bus0.exe_mdu_op;
  assign bus1.mdu_done     = bus0.mdu_done;
  assign bus1.mem_req      = bus0.mem_req;
  assign bus1.mem_ready    = bus0.mem_ready;
  assign bus1.imem_valid   = bus0.imem_valid;
  assign bus1.trap_flush   = bus0.trap_flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble, W_bubble}
  localparam logic [7:0] S_RESET    = 8'b0010_1011;
  localparam logic [7:0] S_NONE     = 8'b0000_0000;
  localparam logic [7:0] S_TRAP     = 8'b0010_1010;
  localparam logic [7:0] S_MEM      = 8'b1101_0101;
  localparam logic [7:0] S_MDU      = 8'b1101_0010;
  localparam logic [7:0] S_REDIRECT = 8'b0010_1000;
  localparam logic [7:0] S_LOAD_USE = 8'b1100_1000;
  localparam logic [7:0] S_FETCH    = 8'b1010_0000;

  int n_tests = 0;
  int n_fail  = 0;
  int starts;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] strobes0();
    return {bus0.regF_stall, bus0.regD_stall, bus0.regD_bubble, bus0.regE_stall,
            bus0.regE_bubble, bus0.regM_stall, bus0.regM_bubble, bus0.regW_bubble};
  endfunction

  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus0.dec_rs1      = 5'd0;
    bus0.dec_rs2      = 5'd0;
    bus0.dec_rs1_ren  = 1'b0;
    bus0.dec_rs2_ren  = 1'b0;
    bus0.exe_is_load  = 1'b0;
    bus0.exe_rd       = 5'd0;
    bus0.exe_redirect = 1'b0;
    bus0.exe_mdu_op   = 1'b0;
    bus0.mdu_done     = 1'b0;
    bus0.mem_req      = 1'b0;
    bus0.mem_ready    = 1'b0;
    bus0.imem_valid   = 1'b1;
    bus0.trap_flush   = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_strobes",   32'(strobes0()),         32'(S_RESET));
    check("rst_stall_cnt", bus0.stall_cnt,          32'd0);
    check("rst_mdu_start", 32'(bus0.mdu_start),     32'd0);
    rst = 1'b0;
    settle();
    check("idle_strobes",  32'(strobes0()),         32'(S_NONE));

    // Load-use on rs2, then the same with rd=x0.
    bus0.exe_is_load = 1'b1; bus0.exe_rd = 5'd5; bus0.dec_rs2 = 5'd5; bus0.dec_rs2_ren = 1'b1;
    settle();
    check("lu_rs2", 32'(strobes0()), 32'(S_LOAD_USE));
    tick();
    bus0.exe_rd = 5'd0; bus0.dec_rs2 = 5'd0;
    settle();
    check("lu_rd0", 32'(strobes0()), 32'(S_NONE));
    tick();
    check("lu_stall_cnt", bus0.stall_cnt, 32'd1);

    // Load-use on rs1, gated by its read enable.
    idle();
    bus0.exe_is_load = 1'b1; bus0.exe_rd = 5'd7; bus0.dec_rs1 = 5'd7; bus0.dec_rs1_ren = 1'b1;
    settle();
    check("lu_rs1", 32'(strobes0()), 32'(S_LOAD_USE));
    bus0.dec_rs1_ren = 1'b0;
    settle();
    check("lu_rs1_noren", 32'(strobes0()), 32'(S_NONE));

    // Redirect outranks load-use and counts as a flush.
    bus0.dec_rs1_ren = 1'b1; bus0.exe_redirect = 1'b1;
    settle();
    check("redir_over_lu", 32'(strobes0()), 32'(S_REDIRECT));
    tick();
    check("redir_flush_cnt", bus0.flush_cnt, 32'd1);
    check("redir_stall_cnt", bus0.stall_cnt, 32'd1);

    idle();
    bus0.imem_valid = 1'b0;
    settle();
    check("fetch_invalid", 32'(strobes0()), 32'(S_FETCH));
    tick();

    // Memory wait hides a redirect, which is not counted.
    idle();
    bus0.mem_req = 1'b1; bus0.mem_ready = 1'b0; bus0.exe_redirect = 1'b1;
    settle();
    check("mem_over_redir", 32'(strobes0()), 32'(S_MEM));
    tick();
    check("mem_flush_cnt", bus0.flush_cnt, 32'd1);
    check("mem_stall_cnt", bus0.stall_cnt, 32'd3);
    bus0.mem_ready = 1'b1;
    settle();
    check("mem_ready_redir", 32'(strobes0()), 32'(S_REDIRECT));

    // MDU op: start in cycle 0, done in cycle 10.
    do_reset();
    bus0.exe_mdu_op = 1'b1;
    settle();
    check("mdu_c0_strobes", 32'(strobes0()), 32'(S_MDU));
    check("mdu_c0_nostart", 32'(bus0.mdu_start), 32'd0);
    tick();
    check("mdu_start_pulse", 32'(bus0.mdu_start), 32'd1);
    starts = int'(bus0.mdu_start);
    for (int k = 1; k <= 9; k++) begin
      check($sformatf("mdu_wait_c%0d", k), 32'(strobes0()), 32'(S_MDU));
      tick();
      starts += int'(bus0.mdu_start);
    end
    bus0.mdu_done = 1'b1;
    settle();
    check("mdu_done_strobes", 32'(strobes0()), 32'(S_NONE));
    tick();
    starts += int'(bus0.mdu_start);
    bus0.mdu_done = 1'b0; bus0.exe_mdu_op = 1'b0;
    settle();
    check("mdu_stall_cnt", bus0.stall_cnt, 32'd10);
    check("mdu_one_start", 32'(starts), 32'd1);
    check("mdu_after_run", 32'(strobes0()), 32'(S_NONE));

    // Memory wait inside MDU_WAIT freezes the wait counter (small instance, timeout 4).
    do_reset();
    bus0.exe_mdu_op = 1'b1;
    tick();
    repeat (2) tick();
    bus0.mem_req = 1'b1; bus0.mem_ready = 1'b0;
    settle();
    check("mdu_mem_strobes", 32'(strobes0()), 32'(S_MEM));
    repeat (3) tick();
    check("mdu_mem_frozen", 32'(bus1.mdu_timeout), 32'd0);
    bus0.mem_ready = 1'b1;
    settle();
    check("mdu_mem_resume", 32'(strobes0()), 32'(S_MDU));
    tick();
    check("to_after_3", 32'(bus1.mdu_timeout), 32'd0);
    tick();
    check("to_after_4", 32'(bus1.mdu_timeout), 32'd1);
    repeat (3) tick();
    check("to_sticky", 32'(bus1.mdu_timeout), 32'd1);
    check("to_still_wait", 32'(strobes0()), 32'(S_MDU));
    check("to_big_clear", 32'(bus0.mdu_timeout), 32'd0);
    bus0.mdu_done = 1'b1;
    tick();
    bus0.mdu_done = 1'b0; bus0.exe_mdu_op = 1'b0;
    settle();
    check("to_after_done", 32'(bus1.mdu_timeout), 32'd1);

    // Trap beats redirect and load-use in MDU_WAIT.
    do_reset();
    bus0.exe_mdu_op = 1'b1;
    tick();
    tick();
    bus0.trap_flush = 1'b1; bus0.exe_redirect = 1'b1;
    bus0.exe_is_load = 1'b1; bus0.exe_rd = 5'd5; bus0.dec_rs1 = 5'd5; bus0.dec_rs1_ren = 1'b1;
    settle();
    check("trap_strobes", 32'(strobes0()), 32'(S_TRAP));
    check("trap_kill_pre", 32'(bus0.mdu_kill), 32'd0);
    tick();
    idle();
    settle();
    check("trap_kill", 32'(bus0.mdu_kill), 32'd1);
    check("trap_flush_cnt", bus0.flush_cnt, 32'd1);
    check("trap_run", 32'(strobes0()), 32'(S_NONE));
    tick();
    check("trap_kill_once", 32'(bus0.mdu_kill), 32'd0);

    // Counter saturation: 20 stall cycles.
    do_reset();
    bus0.imem_valid = 1'b0;
    repeat (20) tick();
    check("sat_cnt4", 32'(bus1.stall_cnt), 32'd15);
    check("sat_cnt32", bus0.stall_cnt, 32'd20);

    // Reset asserted mid-run while in MDU_WAIT with timeout already set.
    idle();
    bus0.exe_mdu_op = 1'b1;
    repeat (6) tick();
    check("mid_pre_to", 32'(bus1.mdu_timeout), 32'd1);
    rst = 1'b1;
    settle();
    check("mid_rst_strobes", 32'(strobes0()), 32'(S_RESET));
    check("mid_rst_stall", bus0.stall_cnt, 32'd0);
    check("mid_rst_flush", bus0.flush_cnt, 32'd0);
    check("mid_rst_to", 32'(bus1.mdu_timeout), 32'd0);
    check("mid_rst_start", 32'(bus0.mdu_start), 32'd0);
    tick();
    rst = 1'b0;
    bus0.exe_mdu_op = 1'b0;
    settle();
    check("mid_rst_run", 32'(strobes0()), 32'(S_NONE));
    bus0.exe_mdu_op = 1'b1;
    settle();
    check("mid_rst_restart", 32'(strobes0()), 32'(S_MDU));
    tick();
    check("mid_rst_start2", 32'(bus0.mdu_start), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
